// File: rtl/fpu_pkg.sv
// Shared types and constants for the FPU rounding/packing stage.
//   frm_e     : rounding-mode encoding (101..111 are treated as RNE by users)
//   FL_*      : bit positions inside the 5-bit {NV, DZ, OF, UF, NX} flag vector
//   CANON_NAN : the single quiet NaN every NaN input collapses to
//   fp_ext_t  : 35-bit extended result {sign, exp, frac, g, r, s}
package fpu_pkg;

  typedef enum logic [2:0] {
    FrmRne = 3'b000,
    FrmRtz = 3'b001,
    FrmRdn = 3'b010,
    FrmRup = 3'b011,
    FrmRmm = 3'b100
  } frm_e;

  localparam int unsigned FL_NV = 4;
  localparam int unsigned FL_DZ = 3;
  localparam int unsigned FL_OF = 2;
  localparam int unsigned FL_UF = 1;
  localparam int unsigned FL_NX = 0;

  localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
    logic        g;
    logic        r;
    logic        s;
  } fp_ext_t;

endpackage

// File: rtl/fpu_round_decide.sv
// Rounding decision for one finite operand.
//   sign, lsb, g, r, s : sign bit, fraction LSB and guard/round/sticky bits
//   frm                : rounding mode (unknown encodings round to nearest even)
//   inc                : add one ulp to the magnitude
//   inx                : result is inexact
module fpu_round_decide
  import fpu_pkg::*;
(
  input  logic       sign,
  input  logic       lsb,
  input  logic       g,
  input  logic       r,
  input  logic       s,
  input  logic [2:0] frm,
  output logic       inc,
  output logic       inx
);

  always_comb begin
    inx = g | r | s;
    inc = 1'b0;
    case (frm)
      FrmRtz:  inc = 1'b0;
      FrmRdn:  inc = sign & inx;
      FrmRup:  inc = ~sign & inx;
      FrmRmm:  inc = g;
      default: inc = g & (r | s | lsb);
    endcase
  end

endmodule

// File: rtl/fpu_round.sv
// Two-stage rounding and packing stage for single-precision add/sub results.
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid/in_ready   : input handshake; in_data is {sign, exp, frac, g, r, s}
//   in_frm              : rounding mode
//   flush               : drop everything in flight at the next edge
//   out_valid/out_ready : output handshake
//   out_data, out_flags : IEEE single word and {NV, DZ, OF, UF, NX}
// Stage A holds classification and the rounding decision; stage B holds the
// finished word and flags and drives the outputs straight from its registers.
module fpu_round
  import fpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [34:0] in_data,
  input  logic [2:0]  in_frm,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [4:0]  out_flags
);

  fp_ext_t in_ext;
  assign in_ext = in_data;

  // Input classification and rounding decision
  logic in_special, in_inf, in_nan, in_snan, in_inc, in_inx, in_uf, in_sat;

  fpu_round_decide u_decide (
    .sign (in_ext.sign),
    .lsb  (in_ext.frac[0]),
    .g    (in_ext.g),
    .r    (in_ext.r),
    .s    (in_ext.s),
    .frm  (in_frm),
    .inc  (in_inc),
    .inx  (in_inx)
  );

  always_comb begin
    in_special = (in_ext.exp == 8'hFF);
    in_inf     = in_special & (in_ext.frac == 23'h0);
    in_nan     = in_special & (in_ext.frac != 23'h0);
    in_snan    = in_nan & ~in_ext.frac[22];
    in_uf      = (in_ext.exp == 8'h00) & in_inx;
    // Modes whose overflow result saturates at max finite instead of infinity
    in_sat     = (in_frm == FrmRtz) |
                 ((in_frm == FrmRdn) & ~in_ext.sign) |
                 ((in_frm == FrmRup) & in_ext.sign);
  end

  // Handshake
  logic va_q, vb_q, adv_a, adv_b;

  assign adv_b     = ~vb_q | out_ready;
  assign adv_a     = ~va_q | adv_b;
  assign in_ready  = adv_a | flush | ~rst_n;
  assign out_valid = vb_q;

  // Stage A
  logic        a_sign_q, a_inc_q, a_inx_q, a_inf_q, a_nan_q, a_snan_q, a_uf_q, a_sat_q;
  logic [30:0] a_mag_q;

  // Stage B next-state: increment and overflow fixup
  logic [30:0] mag_rnd;
  logic        ovf;
  logic [31:0] b_data_d;
  logic [4:0]  b_flags_d;
  logic [31:0] b_data_q;
  logic [4:0]  b_flags_q;

  always_comb begin
    // Fraction carry ripples into the exponent through the plain 31-bit add
    mag_rnd   = a_mag_q + {30'h0, a_inc_q};
    ovf       = (mag_rnd[30:23] == 8'hFF);
    b_data_d  = {a_sign_q, mag_rnd};
    b_flags_d = 5'h0;
    if (a_nan_q) begin
      b_data_d         = CANON_NAN;
      b_flags_d[FL_NV] = a_snan_q;
    end else if (a_inf_q) begin
      b_data_d = {a_sign_q, 8'hFF, 23'h0};
    end else begin
      b_flags_d[FL_NX] = a_inx_q;
      b_flags_d[FL_UF] = a_uf_q;
      if (ovf) begin
        b_flags_d[FL_OF] = 1'b1;
        b_flags_d[FL_NX] = 1'b1;
        b_data_d = a_sat_q ? {a_sign_q, 31'h7F7F_FFFF} : {a_sign_q, 31'h7F80_0000};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      va_q      <= 1'b0;
      vb_q      <= 1'b0;
      b_data_q  <= 32'h0;
      b_flags_q <= 5'h0;
      a_sign_q  <= 1'b0;
      a_mag_q   <= 31'h0;
      a_inc_q   <= 1'b0;
      a_inx_q   <= 1'b0;
      a_inf_q   <= 1'b0;
      a_nan_q   <= 1'b0;
      a_snan_q  <= 1'b0;
      a_uf_q    <= 1'b0;
      a_sat_q   <= 1'b0;
    end else begin
      if (adv_b) begin
        vb_q <= va_q;
        if (va_q) begin
          b_data_q  <= b_data_d;
          b_flags_q <= b_flags_d;
        end
      end
      if (adv_a) begin
        va_q <= in_valid;
        if (in_valid) begin
          a_sign_q <= in_ext.sign;
          a_mag_q  <= {in_ext.exp, in_ext.frac};
          a_inc_q  <= in_inc;
          a_inx_q  <= in_inx;
          a_inf_q  <= in_inf;
          a_nan_q  <= in_nan;
          a_snan_q <= in_snan;
          a_uf_q   <= in_uf;
          a_sat_q  <= in_sat;
        end
      end
      if (flush) begin
        va_q <= 1'b0;
        vb_q <= 1'b0;
      end
    end
  end

  assign out_data  = b_data_q;
  assign out_flags = b_flags_q;

endmodule
